// File: rtl/vga_fb_dbuf.sv
// Double-buffered NES framebuffer: the PPU fills the back bank while VGA scans the front bank through the palette ROM.
// Banks swap in vblank after frame end. The new back bank can be auto-cleared after each swap.
module vga_fb_dbuf #(
  parameter int unsigned FB_W       = 256,
  parameter int unsigned FB_H       = 240,
  parameter int unsigned XW         = 8,
  parameter int unsigned YW         = 8,
  parameter bit          CLEAR_EN   = 1'b1,
  parameter logic [5:0]  CLEAR_CODE = 6'h0F
) (
  input  logic          ppu_ctl_clk,
  input  logic          rst_n,
  input  logic          CS,
  input  logic [XW-1:0] ppu_ptr_x,
  input  logic [YW-1:0] ppu_ptr_y,
  input  logic [5:0]    ppu_DI,
  input  logic          ppu_frame_done,
  input  logic [XW-1:0] pix_ptr_x,
  input  logic [YW-1:0] pix_ptr_y,
  input  logic          pix_vblank,
  output logic [8:0]    rgb,
  output logic          fb_sel,
  output logic          swap_pending,
  output logic          clr_busy
);

  localparam int unsigned NPIX = FB_W * FB_H;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [AW-1:0] LAST_A = AW'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, PENDING, CLEAR} state_t;

  state_t        state;
  logic          done_seen;
  logic [AW-1:0] clr_cnt;

  logic [5:0]    bank0 [NPIX];
  logic [5:0]    bank1 [NPIX];

  logic          wr_ok, mem_we, rd_ok;
  logic [AW-1:0] wr_addr, mem_wa, rd_addr;
  logic [5:0]    mem_wd;

  logic          rd_ok_q, rd_bank_q, code_ok_q;
  logic [AW-1:0] rd_addr_q;
  logic [5:0]    code_q;

  function automatic logic [8:0] nes_pal9(input logic [5:0] c);
    case (c)
      6'h00: return 9'h092; 6'h01: return 9'h00B; 6'h02: return 9'h004; 6'h03: return 9'h084;
      6'h04: return 9'h083; 6'h05: return 9'h0C1; 6'h06: return 9'h080; 6'h07: return 9'h088;
      6'h08: return 9'h048; 6'h09: return 9'h010; 6'h0A: return 9'h010; 6'h0B: return 9'h010;
      6'h0C: return 9'h00A;
      6'h10: return 9'h124; 6'h11: return 9'h015; 6'h12: return 9'h04E; 6'h13: return 9'h0CE;
      6'h14: return 9'h10D; 6'h15: return 9'h10B; 6'h16: return 9'h109; 6'h17: return 9'h0D0;
      6'h18: return 9'h090; 6'h19: return 9'h058; 6'h1A: return 9'h018; 6'h1B: return 9'h019;
      6'h1C: return 9'h01B;
      6'h20: return 9'h1BE; 6'h21: return 9'h0A6; 6'h22: return 9'h0DE; 6'h23: return 9'h15E;
      6'h24: return 9'h196; 6'h25: return 9'h195; 6'h26: return 9'h19B; 6'h27: return 9'h1A1;
      6'h28: return 9'h128; 6'h29: return 9'h0E8; 6'h2A: return 9'h0B1; 6'h2B: return 9'h073;
      6'h2C: return 9'h06E; 6'h2D: return 9'h092;
      6'h30: return 9'h1FF; 6'h31: return 9'h176; 6'h32: return 9'h16E; 6'h33: return 9'h1AE;
      6'h34: return 9'h1AE; 6'h35: return 9'h1AE; 6'h36: return 9'h1AD; 6'h37: return 9'h1AC;
      6'h38: return 9'h1B3; 6'h39: return 9'h173; 6'h3A: return 9'h174; 6'h3B: return 9'h135;
      6'h3C: return 9'h136; 6'h3D: return 9'h124;
      default: return 9'h000;
    endcase
  endfunction

  // Single write port shared by the PPU and the clearer; clr_busy blocks the PPU, so they never collide.
  always_comb begin
    wr_ok   = CS && (32'(ppu_ptr_x) < FB_W) && (32'(ppu_ptr_y) < FB_H) && !clr_busy;
    wr_addr = AW'(32'(ppu_ptr_y) * FB_W + 32'(ppu_ptr_x));
    mem_we  = clr_busy || wr_ok;
    mem_wa  = clr_busy ? clr_cnt : wr_addr;
    mem_wd  = clr_busy ? CLEAR_CODE : ppu_DI;
    rd_ok   = (32'(pix_ptr_x) < FB_W) && (32'(pix_ptr_y) < FB_H);
    rd_addr = AW'(32'(pix_ptr_y) * FB_W + 32'(pix_ptr_x));
  end

  always_ff @(posedge ppu_ctl_clk) begin
    if (mem_we) begin
      if (fb_sel) bank0[mem_wa] <= mem_wd;
      else        bank1[mem_wa] <= mem_wd;
    end
    code_q <= rd_bank_q ? bank1[rd_addr_q] : bank0[rd_addr_q];
  end

  // Bank select is captured with the pointer so a swap cannot split one pixel across banks.
  always_ff @(posedge ppu_ctl_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ok_q   <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      code_ok_q <= 1'b0;
      rgb       <= '0;
    end else begin
      rd_ok_q   <= rd_ok;
      rd_bank_q <= fb_sel;
      rd_addr_q <= rd_ok ? rd_addr : '0;
      code_ok_q <= rd_ok_q;
      rgb       <= code_ok_q ? nes_pal9(code_q) : '0;
    end
  end

  always_ff @(posedge ppu_ctl_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fb_sel       <= 1'b0;
      swap_pending <= 1'b0;
      clr_busy     <= 1'b0;
      clr_cnt      <= '0;
      done_seen    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ppu_frame_done) begin
            state        <= PENDING;
            swap_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (pix_vblank) begin
            fb_sel       <= ~fb_sel;
            swap_pending <= 1'b0;
            if (CLEAR_EN) begin
              state     <= CLEAR;
              clr_busy  <= 1'b1;
              clr_cnt   <= '0;
              done_seen <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        CLEAR: begin
          if (ppu_frame_done) done_seen <= 1'b1;
          if (clr_cnt == LAST_A) begin
            clr_cnt   <= '0;
            clr_busy  <= 1'b0;
            done_seen <= 1'b0;
            if (done_seen || ppu_frame_done) begin
              state        <= PENDING;
              swap_pending <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_dbuf.sv
// Directed self-checking bench for vga_fb_dbuf on an 8x4 framebuffer with auto-clear enabled.
module tb_vga_fb_dbuf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs;
  logic [3:0] ppu_x;
  logic [2:0] ppu_y;
  logic [5:0] ppu_di;
  logic       frame_done;
  logic [3:0] pix_x;
  logic [2:0] pix_y;
  logic       vblank;
  logic [8:0] rgb;
  logic       fb_sel, swap_pending, clr_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_fb_dbuf #(
    .FB_W(8), .FB_H(4), .XW(4), .YW(3), .CLEAR_EN(1'b1), .CLEAR_CODE(6'h0F)
  ) u_dut (
    .ppu_ctl_clk(clk), .rst_n(rst_n), .CS(cs),
    .ppu_ptr_x(ppu_x), .ppu_ptr_y(ppu_y), .ppu_DI(ppu_di),
    .ppu_frame_done(frame_done),
    .pix_ptr_x(pix_x), .pix_ptr_y(pix_y), .pix_vblank(vblank),
    .rgb(rgb), .fb_sel(fb_sel), .swap_pending(swap_pending), .clr_busy(clr_busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_px(input int x, input int y, input logic [5:0] d);
    cs = 1'b1; ppu_x = 4'(x); ppu_y = 3'(y); ppu_di = d;
    tick();
    cs = 1'b0;
  endtask

  task automatic rd_px(input int x, input int y, output logic [8:0] v);
    pix_x = 4'(x); pix_y = 3'(y);
    tick(); tick(); tick();
    v = rgb;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (clr_busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] v;
    logic [8:0] e;
    int n;

    rst_n = 1'b0; cs = 1'b0; ppu_x = '0; ppu_y = '0; ppu_di = '0;
    frame_done = 1'b0; pix_x = '0; pix_y = '0; vblank = 1'b0;
    repeat (3) tick();
    chk("rst_rgb", rgb, 0);
    chk("rst_fb_sel", fb_sel, 0);
    chk("rst_pending", swap_pending, 0);
    chk("rst_clr_busy", clr_busy, 0);
    rst_n = 1'b1;
    tick();

    // Fill back bank 1, then hold the swap request outside vblank.
    wr_px(5, 3, 6'h03);
    wr_px(2, 1, 6'h03);
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    repeat (100) tick();
    chk("pend_held", swap_pending, 1);
    chk("pend_fb_sel", fb_sel, 0);
    vblank = 1'b1; tick(); vblank = 1'b0;
    chk("swap1_fb_sel", fb_sel, 1);
    chk("swap1_pending", swap_pending, 0);
    chk("swap1_clr_busy", clr_busy, 1);

    // Clear of bank 0: frame_done mid-clear, and a late write to an already-cleared address.
    n = 0;
    while (clr_busy && n < 100) begin
      if (n == 10) frame_done = 1'b1;
      if (n == 28) begin cs = 1'b1; ppu_x = 4'd0; ppu_y = 3'd0; ppu_di = 6'h30; end
      tick();
      frame_done = 1'b0; cs = 1'b0;
      n++;
    end
    chk("clear1_len", n, 32);
    chk("clear1_pending_after", swap_pending, 1);
    chk("clear1_fb_sel", fb_sel, 1);

    // Read latency on the front bank: out-of-range first, then a valid pixel.
    rd_px(0, 4, v);
    chk("rd_y_oor", v, 0);
    pix_x = 4'd5; pix_y = 3'd3;
    tick(); tick();
    chk("lat_n1", rgb, 0);
    tick();
    chk("lat_n2", rgb, 9'h084);

    // Back-bank writes while pending must not disturb the front.
    wr_px(2, 1, 6'h30);
    wr_px(8, 0, 6'h30);
    rd_px(2, 1, v);
    chk("iso_front", v, 9'h084);

    vblank = 1'b1; tick(); vblank = 1'b0;
    chk("swap2_fb_sel", fb_sel, 0);
    chk("swap2_pending", swap_pending, 0);
    chk("swap2_clr_busy", clr_busy, 1);
    wait_clear(n);
    chk("clear2_len", n, 32);
    chk("clear2_pending_after", swap_pending, 0);
    chk("clear2_fb_sel", fb_sel, 0);

    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        rd_px(x, y, v);
        e = (x == 2 && y == 1) ? 9'h1FF : 9'h000;
        chk($sformatf("bank0_px_%0d_%0d", x, y), v, e);
      end
    end
    rd_px(8, 0, v);
    chk("rd_x_oor", v, 0);

    // Swap-edge case: frame_done and vblank together only arm the swap.
    wr_px(3, 2, 6'h30);
    frame_done = 1'b1; vblank = 1'b1; tick(); frame_done = 1'b0; vblank = 1'b0;
    chk("edge_pending", swap_pending, 1);
    chk("edge_fb_sel", fb_sel, 0);
    repeat (3) tick();
    chk("edge_fb_sel_held", fb_sel, 0);
    vblank = 1'b1; tick(); vblank = 1'b0;
    chk("swap3_fb_sel", fb_sel, 1);
    chk("swap3_clr_busy", clr_busy, 1);
    rd_px(3, 2, v);
    chk("swap3_rd", v, 9'h1FF);
    chk("midclear_busy", clr_busy, 1);

    // Asynchronous reset in the middle of a clear.
    rst_n = 1'b0;
    #2;
    chk("arst_rgb", rgb, 0);
    chk("arst_fb_sel", fb_sel, 0);
    chk("arst_pending", swap_pending, 0);
    chk("arst_clr_busy", clr_busy, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_clr_busy", clr_busy, 0);
    chk("post_rst_pending", swap_pending, 0);
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    chk("post_rst_arm", swap_pending, 1);
    chk("post_rst_fb_sel", fb_sel, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
